fifo_loader: RTL

FIFO_LOADER -- requirements
Module: fifo_loader

---
 rtl/fifo_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_loader.sv
// Staging register file that streams its contents into a DEPTH-deep delay FIFO,
// followed by DEPTH zero beats that push the data out to the FIFO's q.
module fifo_loader #(
  parameter int DEPTH = 8,
  parameter int BITS  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [BITS-1:0]          wr_data,
  input  logic                     start,
  input  logic                     hold,
  output logic                     fifo_en,
  output logic [BITS-1:0]          fifo_d,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [BITS-1:0]       stage_q [DEPTH];
  logic                  done_q, wr_err_q;
  logic                  addr_ok, wr_ok;

  // Only non-power-of-two depths can see an out-of-range index.
  generate
    if (DEPTH == (1 << AW)) begin : g_pow2
      assign addr_ok = 1'b1;
    end else begin : g_npow2
      localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
      assign addr_ok = {1'b0, wr_addr} < DEPTH_W;
    end
  endgenerate

  assign wr_ok   = wr_valid && (state_q == S_IDLE) && addr_ok;
  assign busy    = (state_q == S_LOAD) || (state_q == S_FLUSH);
  assign fifo_en = busy && !hold;
  assign fifo_d  = (state_q == S_LOAD) ? stage_q[cnt_q] : '0;
  assign done    = done_q;
  assign wr_err  = wr_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (fifo_en) begin
          if (cnt_q == LAST) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (fifo_en) begin
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= (state_d == S_DONE);
      wr_err_q <= wr_valid && !wr_ok;
    end
  end

  // A write coinciding with start lands before the first LOAD beat reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_addr == AW'(i)) stage_q[i] <= wr_data;
    end
  end

endmodule
